// File: rtl/tv_sweep_capture.sv
// rtl/tv_sweep_capture.sv - exhaustive input sweep with truth-table, MISR capture and golden compare
module tv_sweep_capture #(
    parameter int                   N_WIDTH   = 3,
    parameter int                   SETTLE    = 1,
    parameter int                   SIG_WIDTH = 16,
    parameter logic [SIG_WIDTH-1:0] POLY      = 16'h1021,
    parameter logic [SIG_WIDTH-1:0] SEED      = '0
) (
    input  logic                       CK,
    input  logic                       reset,
    input  logic                       start,
    input  logic [(1<<N_WIDTH)-1:0]    golden,
    output logic [N_WIDTH-1:0]         dut_in,
    input  logic                       dut_out,
    output logic                       busy,
    output logic                       done,
    output logic [(1<<N_WIDTH)-1:0]    resp_vec,
    output logic [SIG_WIDTH-1:0]       signature,
    output logic                       mismatch,
    output logic [N_WIDTH:0]           mismatch_count
);

    localparam int                 NVEC          = 1 << N_WIDTH;
    localparam logic [N_WIDTH-1:0] LAST_IDX      = N_WIDTH'(NVEC - 1);
    localparam logic [3:0]         SETTLE_RELOAD = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_APPLY   = 2'd1,
        S_COMPARE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [N_WIDTH-1:0]     idx_q, idx_d;
    logic [3:0]             settle_q, settle_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [NVEC-1:0]        resp_q, resp_d;
    logic [SIG_WIDTH-1:0]   sig_q, sig_d;
    logic                   mm_q, mm_d;
    logic [N_WIDTH:0]       mmcnt_q, mmcnt_d;

    logic [NVEC-1:0]        diff;
    logic [N_WIDTH:0]       pop;
    logic [SIG_WIDTH-1:0]   sig_step;

    // State and result registers; reset wins over everything else
    always_ff @(posedge CK) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            settle_q <= SETTLE_RELOAD;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            resp_q   <= '0;
            sig_q    <= SEED;
            mm_q     <= 1'b0;
            mmcnt_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            resp_q   <= resp_d;
            sig_q    <= sig_d;
            mm_q     <= mm_d;
            mmcnt_q  <= mmcnt_d;
        end
    end

    // Compare helpers and the MISR step for the response sampled this cycle
    always_comb begin
        diff = resp_q ^ golden;
        pop  = '0;
        for (int i = 0; i < NVEC; i++) begin
            pop = pop + {{N_WIDTH{1'b0}}, diff[i]};
        end
        sig_step = {sig_q[SIG_WIDTH-2:0], 1'b0}
                 ^ (sig_q[SIG_WIDTH-1] ? POLY : {SIG_WIDTH{1'b0}})
                 ^ {{(SIG_WIDTH-1){1'b0}}, dut_out};
    end

    // Next-state logic: sweep indices, sample responses, then one compare cycle
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        busy_d   = busy_q;
        done_d   = done_q;
        resp_d   = resp_q;
        sig_d    = sig_q;
        mm_d     = mm_q;
        mmcnt_d  = mmcnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_APPLY;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    mm_d     = 1'b0;
                    mmcnt_d  = '0;
                    idx_d    = '0;
                    resp_d   = '0;
                    sig_d    = SEED;
                    settle_d = SETTLE_RELOAD;
                end
            end
            S_APPLY: begin
                if (settle_q != 4'd0) begin
                    settle_d = settle_q - 4'd1;
                end else begin
                    resp_d[idx_q] = dut_out;
                    sig_d         = sig_step;
                    if (idx_q != LAST_IDX) begin
                        idx_d    = idx_q + N_WIDTH'(1);
                        settle_d = SETTLE_RELOAD;
                    end else begin
                        state_d = S_COMPARE;
                    end
                end
            end
            S_COMPARE: begin
                mm_d    = |diff;
                mmcnt_d = pop;
                state_d = S_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                idx_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign dut_in         = idx_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign resp_vec       = resp_q;
    assign signature      = sig_q;
    assign mismatch       = mm_q;
    assign mismatch_count = mmcnt_q;

endmodule

// File: tb/tb_tv_sweep_capture.sv
// tb/tb_tv_sweep_capture.sv - directed bench for tv_sweep_capture
module tb_tv_sweep_capture;

    logic        CK;
    logic        reset;
    logic        start1, start3;
    logic [7:0]  golden1, golden3;
    logic [2:0]  dut_in1, dut_in3;
    logic        out1, out3;
    logic        busy1, busy3, done1, done3;
    logic [7:0]  resp1, resp3;
    logic [15:0] sig1, sig3;
    logic        mm1, mm3;
    logic [3:0]  cnt1, cnt3;

    int mode;
    int errors = 0;
    int checks = 0;

    tv_sweep_capture #(.N_WIDTH(3), .SETTLE(1)) u_dut1 (
        .CK(CK), .reset(reset), .start(start1), .golden(golden1),
        .dut_in(dut_in1), .dut_out(out1), .busy(busy1), .done(done1),
        .resp_vec(resp1), .signature(sig1), .mismatch(mm1), .mismatch_count(cnt1)
    );

    tv_sweep_capture #(.N_WIDTH(3), .SETTLE(3)) u_dut3 (
        .CK(CK), .reset(reset), .start(start3), .golden(golden3),
        .dut_in(dut_in3), .dut_out(out3), .busy(busy3), .done(done3),
        .resp_vec(resp3), .signature(sig3), .mismatch(mm3), .mismatch_count(cnt3)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    // Benchmark circuit stand-ins: 0 = AND3, 1 = XOR3, 2 = constant 1
    function automatic logic bench_fn(int m, logic [2:0] v);
        case (m)
            0:       return &v;
            1:       return ^v;
            default: return 1'b1;
        endcase
    endfunction

    always_comb begin
        out1 = bench_fn(mode, dut_in1);
        out3 = bench_fn(mode, dut_in3);
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // SETTLE=1 sweep on u_dut1; start re-asserted during negedge 'repulse' if >= 0
    task automatic sweep1(int repulse, logic [7:0] er, logic [15:0] es, logic em, logic [3:0] ec);
        start1 = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(negedge CK);
            start1 = (j == repulse);
            if (j < 8) begin
                check($sformatf("s1_busy_c%0d", j), busy1, 1);
                check($sformatf("s1_dut_in_c%0d", j), dut_in1, j);
                check($sformatf("s1_done_c%0d", j), done1, 0);
            end else if (j == 8) begin
                check("s1_cmp_busy", busy1, 1);
                check("s1_cmp_dut_in", dut_in1, 7);
                check("s1_cmp_done", done1, 0);
            end else begin
                check("s1_end_busy", busy1, 0);
                check("s1_end_done", done1, 1);
                check("s1_end_dut_in", dut_in1, 0);
                check("s1_resp", resp1, er);
                check("s1_sig", sig1, es);
                check("s1_mm", mm1, em);
                check("s1_cnt", cnt1, ec);
            end
        end
        start1 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        start1  = 1'b0;
        start3  = 1'b0;
        golden1 = 8'h80;
        golden3 = 8'hFF;
        mode    = 0;
        repeat (3) @(negedge CK);
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_resp", resp1, 0);
        check("rst_sig", sig1, 0);
        check("rst_dut_in", dut_in1, 0);
        check("rst_mm", mm1, 0);
        check("rst_cnt", cnt1, 0);
        reset = 1'b0;
        @(negedge CK);

        // AND3 against golden 0x80
        mode = 0;
        sweep1(-1, 8'h80, 16'h0001, 1'b0, 4'd0);
        @(negedge CK);
        check("and3_hold_done", done1, 1);
        check("and3_hold_resp", resp1, 8'h80);

        // Parity against golden 0x80: responses at 1,2,4,7
        mode = 1;
        sweep1(-1, 8'h96, 16'h0069, 1'b1, 4'd3);

        // SETTLE=3 constant-1 sweep
        mode   = 2;
        start3 = 1'b1;
        for (int j = 0; j < 26; j++) begin
            @(negedge CK);
            start3 = 1'b0;
            if (j < 24) begin
                check($sformatf("s3_busy_c%0d", j), busy3, 1);
                check($sformatf("s3_dut_in_c%0d", j), dut_in3, j / 3);
            end else if (j == 24) begin
                check("s3_cmp_busy", busy3, 1);
                check("s3_cmp_dut_in", dut_in3, 7);
            end else begin
                check("s3_end_busy", busy3, 0);
                check("s3_end_done", done3, 1);
                check("s3_resp", resp3, 8'hFF);
                check("s3_sig", sig3, 16'h00FF);
                check("s3_mm", mm3, 0);
                check("s3_cnt", cnt3, 0);
            end
        end

        // Parity sweep with a start re-pulse mid-sweep
        mode = 1;
        @(negedge CK);
        sweep1(3, 8'h96, 16'h0069, 1'b1, 4'd3);

        // Reset mid-sweep
        mode   = 2;
        start1 = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(negedge CK);
            start1 = 1'b0;
        end
        check("pre_rst_busy", busy1, 1);
        reset = 1'b1;
        @(negedge CK);
        reset = 1'b0;
        check("mid_rst_busy", busy1, 0);
        check("mid_rst_done", done1, 0);
        check("mid_rst_resp", resp1, 0);
        check("mid_rst_sig", sig1, 0);
        check("mid_rst_dut_in", dut_in1, 0);
        @(negedge CK);
        check("post_rst_idle_busy", busy1, 0);
        mode = 0;
        sweep1(-1, 8'h80, 16'h0001, 1'b0, 4'd0);

        // start held high: back-to-back parity sweeps
        mode   = 1;
        start1 = 1'b1;
        for (int j = 0; j < 21; j++) begin
            @(negedge CK);
            if (j < 8) begin
                check($sformatf("bb1_dut_in_c%0d", j), dut_in1, j);
                check($sformatf("bb1_busy_c%0d", j), busy1, 1);
            end else if (j == 8) begin
                check("bb1_cmp_busy", busy1, 1);
            end else if (j == 9) begin
                check("bb1_done", done1, 1);
                check("bb1_busy", busy1, 0);
                check("bb1_resp", resp1, 8'h96);
                check("bb1_sig", sig1, 16'h0069);
                check("bb1_cnt", cnt1, 3);
            end else if (j < 18) begin
                check($sformatf("bb2_dut_in_c%0d", j - 10), dut_in1, j - 10);
                check($sformatf("bb2_busy_c%0d", j - 10), busy1, 1);
                check($sformatf("bb2_done_c%0d", j - 10), done1, 0);
                if (j == 10) begin
                    check("bb2_start_resp", resp1, 0);
                    check("bb2_start_mm", mm1, 0);
                end
            end else if (j == 18) begin
                check("bb2_cmp_busy", busy1, 1);
                start1 = 1'b0;
            end else begin
                check($sformatf("bb2_done_c%0d", j), done1, 1);
                check($sformatf("bb2_busy_c%0d", j), busy1, 0);
                check("bb2_resp", resp1, 8'h96);
                check("bb2_sig", sig1, 16'h0069);
                check("bb2_mm", mm1, 1);
                check("bb2_cnt", cnt1, 3);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tv_sweep_capture.md
Name: tv_sweep_capture

Overview:
- Self-contained on-chip stimulus/response stage for the trojan-detection benchmarks.
- Sweeps every combination of the N-bit input bus into a single-output benchmark circuit (`test_*` instance) and captures its response into a truth-table register and a MISR signature.
- Compares the captured truth table against a golden table and flags mismatches.
- Replaces the open-loop file-writing sweep with a synthesizable, cycle-exact capture stage. It sits directly upstream (drives `N`) and downstream (consumes `output_single`) of the benchmark DUT.

Parameters:
- N_WIDTH, 3, width of DUT input bus; sweep length is 2**N_WIDTH vectors.
- SETTLE, 1, cycles each vector is held before its response is sampled; legal range 1..15.
- SIG_WIDTH, 16, MISR signature width.
- POLY, 16'h1021, MISR feedback polynomial (taps XORed in when the shifted-out bit is 1).
- SEED, 0, MISR value loaded at start of sweep.

Ports:
- CK  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a sweep; sampled only in IDLE or DONE.
- golden  input  2**N_WIDTH  expected truth table; bit i = expected output for input vector i; sampled at the COMPARE edge.
- dut_in  output  N_WIDTH  vector driven to DUT `N` bus; binary value of current index, MSB = N[0].
- dut_out  input  1  DUT `output_single`.
- busy  output  1  high while a sweep or compare is in progress.
- done  output  1  high from sweep completion until next start or reset.
- resp_vec  output  2**N_WIDTH  captured truth table; bit i = dut_out sampled for vector i.
- signature  output  SIG_WIDTH  MISR over responses in index order.
- mismatch  output  1  resp_vec != golden; valid while done=1.
- mismatch_count  output  N_WIDTH+1  popcount(resp_vec ^ golden); valid while done=1.

Behaviour:
- Reset (sync, active-high, overrides start): state=IDLE, dut_in=0, busy=0, done=0, resp_vec=0, signature=SEED, mismatch=0, mismatch_count=0, index=0, settle counter=SETTLE-1.
- States: IDLE, APPLY, COMPARE, DONE.
- IDLE/DONE with start=1 at edge k:
  - state→APPLY, busy=1, done=0, mismatch=0, mismatch_count=0.
  - index=0, dut_in=0, resp_vec=0, signature=SEED, settle counter=SETTLE-1.
- APPLY, counter>0: decrement counter; dut_in held.
- APPLY, counter==0, sample edge:
  - resp_vec[index] <= dut_out.
  - signature <= {signature[SIG_WIDTH-2:0],1'b0} ^ (signature[SIG_WIDTH-1] ? POLY : 0) ^ {{SIG_WIDTH-1{0}}, dut_out}.
  - If index < 2**N_WIDTH-1: index++, dut_in = index+1, counter reloaded to SETTLE-1.
  - If index is last: state→COMPARE, dut_in holds last vector.
- Vector i is applied after edge k+i*SETTLE and sampled at edge k+(i+1)*SETTLE.
- COMPARE (exactly one cycle, busy=1):
  - mismatch <= |(resp_vec ^ golden); mismatch_count <= popcount.
  - state→DONE, busy=0, done=1, dut_in→0.
- Total busy duration = 2**N_WIDTH*SETTLE + 1 cycles.
- DONE: all results held stable; done stays 1 until start (new sweep) or reset.
- start while busy (APPLY/COMPARE): ignored; no restart, no effect on results.
- start held high continuously: a new sweep begins on the first edge in DONE, i.e. back-to-back sweeps with one DONE cycle between.
- reset mid-sweep: all outputs return to reset values at that edge; partial results discarded.
- Index/dut_in never wraps within a sweep; the sweep ends at the last vector.

Test Plan:
- AND3 DUT, SETTLE=1, SEED=0, golden=8'h80, start pulse at edge k → busy high edges k..k+8, done=1 after edge k+9, resp_vec=8'h80, signature=16'h0001, mismatch=0, mismatch_count=0.
- XOR3 (parity) DUT, golden=8'h80 → resp_vec=8'h96, mismatch=1, mismatch_count=3; dut_in sequence 0,1,…,7 one per cycle, then 0.
- SETTLE=3, constant-1 DUT, SEED=0 → each dut_in value held 3 cycles, busy for 25 cycles, resp_vec=8'hFF, golden=8'hFF gives mismatch=0.
- start re-pulsed at sweep cycle 4 → ignored; completion time and results identical to the undisturbed run.
- reset asserted at sweep cycle 5 → next cycle busy=0, done=0, resp_vec=0, signature=SEED, dut_in=0; a subsequent start yields a full correct sweep.
- start held high continuously → two consecutive sweeps with done=1 for exactly one cycle between them; results of each match a single sweep.
